adder_seq_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit additions by time-multiplexing one external 4-bit ripple adder (i_a/i_b/i_cin → o_sum/o_cout), one nibble per clock, LSB first, chaining the carry through an internal register. It sits between a requester using a start/done handshake and the shared adder_4bit instance. It owns operand capture, nibble indexing, carry propagation and result assembly.

---
 rtl/adder_seq_ctrl_if.sv | 36 +++
 rtl/adder_seq_ctrl.sv | 116 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// adder_seq_ctrl_if : requester handshake plus shared 4-bit adder port bundle
// Revision          : 1.0
// ============================================================================
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_ready;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic [3:0]       o_add_a;
  logic [3:0]       o_add_b;
  logic             o_add_cin;
  logic [3:0]       i_add_sum;
  logic             i_add_cout;

  // Controller side
  modport slave (
    input  i_start, i_a, i_b, i_cin, i_add_sum, i_add_cout,
    output o_ready, o_busy, o_done, o_sum, o_cout, o_add_a, o_add_b, o_add_cin
  );

  // Requester / external adder side
  modport master (
    output i_start, i_a, i_b, i_cin, i_add_sum, i_add_cout,
    input  o_ready, o_busy, o_done, o_sum, o_cout, o_add_a, o_add_b, o_add_cin
  );
endinterface
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// adder_seq_ctrl : WIDTH-bit add sequenced nibble-by-nibble through a shared
//                  external 4-bit adder, LSB first, carry chained in a register
// Revision       : 1.0
// ============================================================================
module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  adder_seq_ctrl_if.slave   bus
);
  localparam int c_NIB = WIDTH / 4;
  localparam int c_KW  = (c_NIB > 1) ? $clog2(c_NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_KW-1:0]  r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic             w_last;
  logic [3:0]       w_add_a;
  logic [3:0]       w_add_b;
  logic             w_add_cin;

  assign w_last = (r_k == c_KW'(c_NIB - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_add_a     = 4'd0;
    w_add_b     = 4'd0;
    w_add_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_add_a   = r_a[{r_k, 2'b00} +: 4];
        w_add_b   = r_b[{r_k, 2'b00} +: 4];
        w_add_cin = r_c;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture on accept, one nibble of result per RUN cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_a    <= bus.i_a;
            r_b    <= bus.i_b;
            r_c    <= bus.i_cin;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_k    <= '0;
          end
        end
        S_RUN: begin
          r_sum[{r_k, 2'b00} +: 4] <= bus.i_add_sum;
          r_c                      <= bus.i_add_cout;
          if (w_last) begin
            r_cout <= bus.i_add_cout;
          end else begin
            r_k <= r_k + c_KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_ready   = (r_state == S_IDLE);
  assign bus.o_busy    = (r_state == S_RUN);
  assign bus.o_done    = (r_state == S_DONE);
  assign bus.o_sum     = r_sum;
  assign bus.o_cout    = r_cout;
  assign bus.o_add_a   = w_add_a;
  assign bus.o_add_b   = w_add_b;
  assign bus.o_add_cin = w_add_cin;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_adder_seq_ctrl : directed and random checks of the sequenced adder
// Revision          : 1.0
// ============================================================================
module tb_adder_seq_ctrl;
  localparam int c_WIDTH = 16;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  logic [7:0] r_cin_trace;
  int   r_ready_hi;

  adder_seq_ctrl_if #(.WIDTH(c_WIDTH)) bus ();

  adder_seq_ctrl #(.WIDTH(c_WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // External 4-bit ripple adder
  assign {bus.i_add_cout, bus.i_add_sum} =
      {1'b0, bus.o_add_a} + {1'b0, bus.o_add_b} + {4'b0000, bus.o_add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the controller idle; returns at the o_done negedge
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [16:0] res, output int lat);
    int n;
    n = 0;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_wait", 32'(bus.o_ready), 32'd1);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_cin   = cin;
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    lat         = 1;
    r_cin_trace = '0;
    r_ready_hi  = 0;
    forever begin
      r_cin_trace[lat] = bus.o_add_cin;
      if (bus.o_ready) r_ready_hi++;
      if (bus.o_done || lat >= 7) break;
      @(negedge clk);
      lat++;
    end
    res = {bus.o_cout, bus.o_sum};
  endtask

  logic [16:0] res;
  int          lat;
  int          ndone;
  int          bad_before;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rc;

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_cin   = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ready",   32'(bus.o_ready),   32'd1);
    chk("rst_busy",    32'(bus.o_busy),    32'd0);
    chk("rst_done",    32'(bus.o_done),    32'd0);
    chk("rst_sum",     32'(bus.o_sum),     32'd0);
    chk("rst_cout",    32'(bus.o_cout),    32'd0);
    chk("rst_add_a",   32'(bus.o_add_a),   32'd0);
    chk("rst_add_b",   32'(bus.o_add_b),   32'd0);
    chk("rst_add_cin", 32'(bus.o_add_cin), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add with latency, ready-low window and single-cycle done
    run_op(16'h1234, 16'h4321, 1'b0, res, lat);
    chk("basic_res", 32'(res), 32'h05555);
    chk("basic_lat", 32'(lat), 32'd5);
    chk("basic_ready_low", 32'(r_ready_hi), 32'd0);
    @(negedge clk);
    chk("basic_done_1cyc", 32'(bus.o_done), 32'd0);
    chk("basic_ready_back", 32'(bus.o_ready), 32'd1);
    chk("basic_sum_hold", 32'({bus.o_cout, bus.o_sum}), 32'h05555);

    // Full ripple carry
    run_op(16'hFFFF, 16'h0001, 1'b0, res, lat);
    chk("ripple_res", 32'(res), 32'h10000);
    chk("ripple_cin_trace", 32'(r_cin_trace[4:1]), 32'b1110);
    @(negedge clk);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, res, lat);
    chk("max_cin_res", 32'(res), 32'h1FFFF);
    @(negedge clk);
    run_op(16'h0000, 16'h0000, 1'b1, res, lat);
    chk("zero_cin_res", 32'(res), 32'h00001);
    @(negedge clk);

    // Start held through RUN and DONE with new operands: must be dropped
    bus.i_a = 16'h1111; bus.i_b = 16'h2222; bus.i_cin = 1'b0; bus.i_start = 1'b1;
    @(posedge clk);
    ndone = 0;
    res   = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus.o_done) begin
        ndone++;
        res = {bus.o_cout, bus.o_sum};
      end
      bus.i_start = (cyc <= 5);
      bus.i_a     = 16'h0F0F;
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_res", 32'(res), 32'h03333);
    chk("busy_start_idle", 32'(bus.o_busy), 32'd0);

    // Reset in the third RUN cycle
    bus.i_a = 16'h1234; bus.i_b = 16'h4321; bus.i_cin = 1'b0; bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_ready", 32'(bus.o_ready), 32'd1);
    chk("abort_sum",   32'(bus.o_sum),   32'd0);
    chk("abort_cout",  32'(bus.o_cout),  32'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.o_done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(16'hABCD, 16'h1111, 1'b1, res, lat);
    chk("after_abort_res", 32'(res), 32'h0BCDF);
    @(negedge clk);

    // Reset wins over start on the same edge
    rst = 1'b1; bus.i_start = 1'b1; bus.i_a = 16'h5555;
    @(negedge clk);
    rst = 1'b0; bus.i_start = 1'b0;
    chk("rst_start_busy",  32'(bus.o_busy),  32'd0);
    chk("rst_start_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_start_sum",   32'(bus.o_sum),   32'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.o_done) ndone++;
      @(negedge clk);
    end
    chk("rst_start_no_done", 32'(ndone), 32'd0);

    // Random back-to-back operations
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      bad_before = n_bad;
      run_op(ra, rb, rc, res, lat);
      chk("rand_res", 32'(res), 32'({1'b0, ra} + {1'b0, rb} + {16'h0000, rc}));
      if (n_bad != bad_before) break;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
